// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types and widths for the shared shift datapath
package shifter_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = $clog2(DATA_W);

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        shift_dir_e        dir;
    } shift_req_t;

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - combinational logical left/right shifter
module barrel_shifter
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amt,
    input  shift_dir_e        i_dir,
    output logic [DATA_W-1:0] o_result
);

    // Logical shifts only: vacated bits are always zero, even on right shifts.
    always_comb begin
        o_result = (i_dir == SHIFT_RIGHT) ? (i_data >> i_amt) : (i_data << i_amt);
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;

    // Pick the first active request starting at the pointer and wrapping around.
    always_comb begin : search
        int j;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(r_ptr) + k) % N;
            if (!w_found && req[j]) begin
                w_found   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    // After a granted transfer the winner drops to lowest priority; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - shares one barrel shifter among round-robin requesters
module shifter_arbiter
    import shifter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0][AMT_W-1:0]  req_amt,
    input  logic [NUM_REQ-1:0]             req_dir,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [ID_W-1:0]                out_id,
    output logic [31:0]                    grant_cnt
);

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [ID_W-1:0]     r_out_id;
    logic [31:0]         r_grant_cnt;

    logic                w_can_accept;
    logic [NUM_REQ-1:0]  w_req_masked;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_fire;
    shift_req_t          w_sel;
    logic [DATA_W-1:0]   w_result;

    // Requests are only visible to the arbiter when the output slot can take a result.
    always_comb begin
        w_can_accept = !r_out_valid || out_ready;
        w_req_masked = (w_can_accept && !rst) ? req_valid : '0;
        req_ready    = w_grant;
        w_fire       = |w_grant;
    end

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (w_req_masked),
        .advance   (w_fire),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Route the winner's operands onto the shared shifter.
    always_comb begin
        w_sel.data = req_data[w_grant_idx];
        w_sel.amt  = req_amt[w_grant_idx];
        w_sel.dir  = shift_dir_e'(req_dir[w_grant_idx]);
    end

    barrel_shifter u_shift (
        .i_data   (w_sel.data),
        .i_amt    (w_sel.amt),
        .i_dir    (w_sel.dir),
        .o_result (w_result)
    );

    // Single result slot: reload on a transfer (even while draining), otherwise drain on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_grant_cnt <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_id    <= w_grant_idx;
            r_grant_cnt <= r_grant_cnt + 32'd1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign grant_cnt = r_grant_cnt;

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - self-checking bench for shifter_arbiter
module tb_shifter_arbiter;

    localparam int N = 4;

    logic                  clk;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][31:0]    req_data;
    logic [N-1:0][4:0]     req_amt;
    logic [N-1:0]          req_dir;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_data;
    logic [1:0]            out_id;
    logic [31:0]           grant_cnt;

    shifter_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          id;
    } exp_t;

    exp_t        sb_q[$];
    int          m_ptr;
    logic [31:0] m_cnt;
    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] shift_ref(logic [31:0] d, logic [4:0] a, logic dir);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < int'(a); i++) r = dir ? (r >> 1) : (r << 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already set (edge+2); check outputs, advance the reference model, step one clock.
    task automatic cycle(output int g_out);
        logic        ca;
        logic [3:0]  exp_rdy;
        int          g;
        #1;
        ca = (sb_q.size() == 0) || out_ready;
        g  = -1;
        if (!rst && ca) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(sb_q.size() > 0));
        check("grant_cnt", grant_cnt, m_cnt);
        if (sb_q.size() > 0) begin
            check("out_data", out_data, sb_q[0].d);
            check("out_id", 32'(out_id), 32'(sb_q[0].id));
        end
        if (rst) begin
            sb_q.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            if (sb_q.size() > 0 && out_ready) void'(sb_q.pop_front());
            if (g >= 0) begin
                sb_q.push_back('{d: shift_ref(req_data[g], req_amt[g], req_dir[g]), id: g});
                m_ptr = (g + 1) % N;
                m_cnt = m_cnt + 32'd1;
            end
        end
        g_out = g;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          g;
        int          granted;
        int          cyc;
        logic [31:0] hold_d;
        logic [1:0]  hold_id;

        n_cmp = 0; n_err = 0; m_ptr = 0; m_cnt = 0;
        rst = 1'b1; out_ready = 1'b1; req_valid = 4'hF;
        for (int i = 0; i < N; i++) begin
            req_data[i] = $urandom; req_amt[i] = 5'(i); req_dir[i] = 1'b0;
        end
        @(posedge clk); #2;

        // Reset held with every requester valid: nothing accepted.
        cycle(g); cycle(g);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_grant_cnt", grant_cnt, 32'd0);
        rst = 1'b0;
        cycle(g);
        check("first_grant_id", 32'(out_id), 32'd0);
        req_valid = 4'b0000;
        cycle(g);

        // Single requester, left then right.
        req_valid = 4'b0010; req_data[1] = 32'hA5A5A5A5; req_amt[1] = 5'd4; req_dir[1] = 1'b0;
        cycle(g);
        check("single_left", out_data, 32'h5A5A5A50);
        check("single_id", 32'(out_id), 32'd1);
        req_dir[1] = 1'b1;
        cycle(g);
        check("single_right", out_data, 32'h0A5A5A5A);
        req_valid = 4'b0000;
        cycle(g);

        // Round-robin from a fresh reset with all requesters valid.
        rst = 1'b1;
        cycle(g);
        rst = 1'b0; req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            cycle(g);
            check("rr_order", 32'(out_id), 32'(i % N));
            req_data[i % N] = $urandom; req_amt[i % N] = 5'($urandom_range(0, 31));
            req_dir[i % N] = 1'($urandom_range(0, 1));
        end
        check("rr_grant_cnt", grant_cnt, 32'd6);

        // Backpressure holds the result and blocks acceptance.
        out_ready = 1'b0;
        hold_d = out_data; hold_id = out_id;
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            check("bp_data_hold", out_data, hold_d);
            check("bp_id_hold", 32'(out_id), 32'(hold_id));
            check("bp_ready_zero", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle(g);
        check("bp_resume_id", 32'(out_id), 32'd2);
        req_valid = 4'b0000;
        cycle(g); cycle(g);

        // Shift boundaries.
        req_valid = 4'b0001; req_data[0] = 32'hFFFFFFFF; req_amt[0] = 5'd31; req_dir[0] = 1'b0;
        cycle(g);
        check("bound_left31", out_data, 32'h80000000);
        req_dir[0] = 1'b1;
        cycle(g);
        check("bound_right31", out_data, 32'h00000001);
        req_data[0] = 32'h12345678; req_amt[0] = 5'd0;
        cycle(g);
        check("bound_amt0", out_data, 32'h12345678);
        req_valid = 4'b0000;
        cycle(g);

        // Randomized traffic with random backpressure.
        granted = 0; cyc = 0;
        while (granted < 500 && cyc < 5000) begin
            for (int j = 0; j < N; j++) begin
                if (!req_valid[j] && $urandom_range(0, 1) == 1) begin
                    req_valid[j] = 1'b1;
                    req_data[j]  = $urandom;
                    req_amt[j]   = 5'($urandom_range(0, 31));
                    req_dir[j]   = 1'($urandom_range(0, 1));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(g);
            if (g >= 0) begin
                req_valid[g] = 1'b0;
                granted++;
            end
            cyc++;
        end
        check("rand_completed", 32'(granted >= 500), 32'd1);
        req_valid = 4'b0000; out_ready = 1'b1;
        cycle(g); cycle(g);

        // Reset while a result is stalled: it must be discarded and the pointer cleared.
        req_valid = 4'b0001; req_data[0] = 32'hDEADBEEF; req_amt[0] = 5'd8; req_dir[0] = 1'b1;
        cycle(g);
        req_valid = 4'b0000; out_ready = 1'b0;
        cycle(g);
        rst = 1'b1;
        cycle(g);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        cycle(g);
        req_valid = 4'hF;
        cycle(g);
        check("midrst_ptr_zero", 32'(out_id), 32'd0);
        req_valid = 4'b0000;
        cycle(g); cycle(g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
